// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage core. Sits beside the ID stage
// and decides, every cycle, whether the front end advances, whether a bubble
// is injected into ID/EX, whether IF/ID is flushed for a taken branch, and
// whether the back half of the pipe is frozen on a data-memory stall.
//
// Priority, highest first:
//   1. reset            -> idle outputs
//   2. MemStall_i       -> global freeze; FSM state and down-counter hold
//   3. HOLD state       -> continue a multi-cycle load-use stall
//   4. load-use hit     -> first load-use stall cycle (0-cycle latency)
//   5. otherwise        -> run; flush IF/ID if Branch_i
//
// Parameters:
//   REG_AW     register-index width
//   LOAD_STALL bubble cycles per load-use hazard (1..15)
//   CNT_W      width of the performance counters
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   IDEX_MemRead_i        instruction in ID/EX is a load
//   IDEX_RegRT_i          load destination register
//   IFID_RegRS_i/RegRT_i  source registers of the instruction in IF/ID
//   IFID_UsesRT_i         IF/ID instruction reads RT as a source
//   Branch_i              branch taken, resolved in ID
//   MemStall_i            data memory not ready this cycle
//   WritePC_o             PC write enable
//   WriteIFID_o           IF/ID write enable
//   mux8_o                select bubble (zero control) into ID/EX
//   FlushIFID_o           clear IF/ID on the next edge
//   StallAll_o            freeze ID/EX, EX/MEM, MEM/WB
//   LoadStallCnt_o        load-use stall cycle count (saturating)
//   MemStallCnt_o         memory freeze cycle count (saturating)
//
// Build option:
//   HAZARD_PERF_EN  when defined, the two saturating performance counters are
//                   built; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              IDEX_MemRead_i,
  input  logic [REG_AW-1:0] IDEX_RegRT_i,
  input  logic [REG_AW-1:0] IFID_RegRS_i,
  input  logic [REG_AW-1:0] IFID_RegRT_i,
  input  logic              IFID_UsesRT_i,
  input  logic              Branch_i,
  input  logic              MemStall_i,
  output logic              WritePC_o,
  output logic              WriteIFID_o,
  output logic              mux8_o,
  output logic              FlushIFID_o,
  output logic              StallAll_o,
  output logic [CNT_W-1:0]  LoadStallCnt_o,
  output logic [CNT_W-1:0]  MemStallCnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Remaining stall cycles after the first one, loaded on entry to HOLD.
  localparam logic [3:0] HOLD_INIT = 4'(LOAD_STALL - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_hit;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_bubble;
  logic w_flush;
  logic w_stall_all;

  // Load-use hazard: register 0 is hard-wired and never creates a dependency.
  // RT only matters when the IF/ID instruction actually reads it.
  assign w_hit = IDEX_MemRead_i
               & (IDEX_RegRT_i != '0)
               & ((IDEX_RegRT_i == IFID_RegRS_i)
                  | (IFID_UsesRT_i & (IDEX_RegRT_i == IFID_RegRT_i)));

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and control outputs. Outputs are combinational so a stall
  // takes effect in the same cycle the hazard is visible. The rst_n_i term
  // forces idle outputs while reset is held, even with a hazard on the inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_we     = 1'b1;
    w_ifid_we   = 1'b1;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_stall_all = 1'b0;

    if (!rst_n_i) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
    end else if (MemStall_i) begin
      // Whole pipe frozen: ID/EX still holds the same load, so any hit is
      // simply re-evaluated once the memory stall clears.
      w_pc_we     = 1'b0;
      w_ifid_we   = 1'b0;
      w_stall_all = 1'b1;
    end else if (r_state == ST_HOLD) begin
      w_pc_we   = 1'b0;
      w_ifid_we = 1'b0;
      w_bubble  = 1'b1;
      w_cnt_nxt = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_state_nxt = ST_IDLE;
      end
    end else if (w_hit) begin
      w_pc_we   = 1'b0;
      w_ifid_we = 1'b0;
      w_bubble  = 1'b1;
      if (LOAD_STALL > 1) begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = HOLD_INIT;
      end
    end else begin
      // A branch is only honoured when nothing is stalled; a stalled branch
      // re-resolves later with correct operands.
      w_flush = Branch_i;
    end
  end

  assign WritePC_o   = w_pc_we;
  assign WriteIFID_o = w_ifid_we;
  assign mux8_o      = w_bubble;
  assign FlushIFID_o = w_flush;
  assign StallAll_o  = w_stall_all;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_mem_cnt;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_load_cnt <= '0;
      r_mem_cnt  <= '0;
    end else begin
      if (w_bubble && (r_load_cnt != '1)) begin
        r_load_cnt <= r_load_cnt + CNT_W'(1);
      end
      if (w_stall_all && (r_mem_cnt != '1)) begin
        r_mem_cnt <= r_mem_cnt + CNT_W'(1);
      end
    end
  end

  assign LoadStallCnt_o = r_load_cnt;
  assign MemStallCnt_o  = r_mem_cnt;
`else
  assign LoadStallCnt_o = '0;
  assign MemStallCnt_o  = '0;
`endif

endmodule
